// File: rtl/card_ram_arbiter.sv
// card_ram_arbiter
//   Shares the single-port card RAM between the war game datapath units
//   (0 = dealer, 1 = store, 2 = drawer). Round-robin arbitration, one access
//   in flight at a time, per-requester req/ack handshake.
//
// Ports
//   clock, resetn           rising-edge clock, asynchronous active-low reset
//   req, req_we             per-requester request and write flag
//   req_addr, req_wdata     packed per-requester address / write data
//   gnt, ack                one-hot grant (grant..ack) and one-cycle completion
//   rdata                   read data, updated in the ack cycle of a read
//   busy                    high while an access is in progress
//   ram_addr/wdata/we       registered RAM interface
//   ram_rdata               RAM read data, RD_LAT cycles after ram_addr
module card_ram_arbiter #(
    parameter int NREQ   = 3,
    parameter int AW     = 6,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_wdata,
    output logic               ram_we,
    input  logic [DW-1:0]      ram_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] last;
    logic [IW-1:0] owner;
    logic          owner_we;
    logic [CW-1:0] wait_cnt;
    logic [IW-1:0] pick;
    logic [IW-1:0] scan;
    logic          any_req;

    // Round-robin pick: first active request after the last serviced one.
    always_comb begin
        any_req = 1'b0;
        pick    = last;
        scan    = last;
        for (int k = 1; k <= NREQ; k++) begin
            scan = IW'((int'(last) + k) % NREQ);
            if (!any_req && req[scan]) begin
                any_req = 1'b1;
                pick    = scan;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = owner_we ? DONE : WAIT;
            WAIT:    if (wait_cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            last      <= IW'(NREQ - 1);
            owner     <= '0;
            owner_we  <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            // Write strobe lives only for the ISSUE cycle.
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= pick;
                        owner_we  <= req_we[pick];
                        gnt       <= NREQ'(1) << pick;
                        ram_addr  <= req_addr[int'(pick)*AW +: AW];
                        ram_wdata <= req_wdata[int'(pick)*DW +: DW];
                        ram_we    <= req_we[pick];
                    end
                end
                ISSUE: begin
                    wait_cnt <= CW'(RD_LAT - 1);
                    if (owner_we) ack <= gnt;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rdata <= ram_rdata;
                        ack   <= gnt;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                DONE: begin
                    // Rotate priority so the just-served requester goes last.
                    last <= owner;
                    gnt  <= '0;
                    ack  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_card_ram_arbiter.sv
module tb_card_ram_arbiter;

    localparam int NREQ   = 3;
    localparam int AW     = 6;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;

    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic               ram_we;
    logic [DW-1:0]      ram_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    card_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .resetn(resetn), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
        .rdata(rdata), .busy(busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 7) return 16'h002D;
        return DW'(a * 257) ^ 16'h5A00;
    endfunction

    // Card RAM: synchronous write, RD_LAT-cycle registered read.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] rd_pipe [RD_LAT];
    logic          mem_ready = 1'b0;

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if ({gnt, ack, busy, ram_we} !== '0) $display("FAIL reset_ctrl: got %b want 0", {gnt, ack, busy, ram_we}); else n_pass++;
        n_checks++; if ({ram_addr, ram_wdata, rdata} !== '0) $display("FAIL reset_data: got %h want 0", {ram_addr, ram_wdata, rdata}); else n_pass++;
        @(negedge clock);
        resetn = 1'b1;
        tick();
        n_checks++; if ({gnt, busy} !== '0) $display("FAIL reset_idle: got %b want 0", {gnt, busy}); else n_pass++;
    endtask

    task automatic test_write();
        req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0 +: AW] = 6'd5; req_wdata[0 +: DW] = 16'h0A3C;
        tick();
        n_checks++; if (gnt !== 3'b001) $display("FAIL write_gnt: got %b want 001", gnt); else n_pass++;
        n_checks++; if (ram_we !== 1'b1) $display("FAIL write_we_on: got %b want 1", ram_we); else n_pass++;
        n_checks++; if (ram_addr !== 6'd5) $display("FAIL write_addr: got %0d want 5", ram_addr); else n_pass++;
        n_checks++; if (ram_wdata !== 16'h0A3C) $display("FAIL write_wdata: got %h want 0a3c", ram_wdata); else n_pass++;
        n_checks++; if (ack !== 3'b000) $display("FAIL write_ack_early: got %b want 000", ack); else n_pass++;
        req_addr[0 +: AW] = 6'd9; req_wdata[0 +: DW] = 16'hFFFF;
        tick();
        n_checks++; if (ram_we !== 1'b0) $display("FAIL write_we_off: got %b want 0", ram_we); else n_pass++;
        n_checks++; if (ack !== 3'b001) $display("FAIL write_ack: got %b want 001", ack); else n_pass++;
        n_checks++; if (ram_addr !== 6'd5) $display("FAIL write_addr_hold: got %0d want 5", ram_addr); else n_pass++;
        tick();
        req[0] = 1'b0;
        n_checks++; if ({gnt, ack, busy} !== '0) $display("FAIL write_done: got %b want 0", {gnt, ack, busy}); else n_pass++;
        n_checks++; if (mem[5] !== 16'h0A3C) $display("FAIL write_mem: got %h want 0a3c", mem[5]); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL write_no_regrant: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_contention();
        int order[$];
        int idle_cnt;
        int bad_onehot;
        int bad_rd;
        idle_cnt = 0; bad_onehot = 0; bad_rd = 0;
        do_reset();
        req = 3'b111; req_we = 3'b000; req_addr = {6'd12, 6'd11, 6'd10};
        for (int c = 0; c < 60 && order.size() < 6; c++) begin
            tick();
            if (!$onehot0(gnt)) bad_onehot++;
            if (ack != '0) begin
                order.push_back($clog2(ack));
                if (rdata !== init_val(10 + $clog2(ack))) bad_rd++;
                if (order.size() == 6) req = '0;
            end else if (!busy) begin
                idle_cnt++;
            end
        end
        n_checks++; if (order.size() != 6) $display("FAIL cont_count: got %0d acks want 6", order.size()); else n_pass++;
        for (int i = 0; i < order.size(); i++) begin
            n_checks++; if (order[i] != i % 3) $display("FAIL cont_order[%0d]: got %0d want %0d", i, order[i], i % 3); else n_pass++;
        end
        n_checks++; if (bad_onehot != 0) $display("FAIL cont_onehot: got %0d bad cycles want 0", bad_onehot); else n_pass++;
        n_checks++; if (bad_rd != 0) $display("FAIL cont_rdata: got %0d bad reads want 0", bad_rd); else n_pass++;
        n_checks++; if (idle_cnt != 5) $display("FAIL cont_idle: got %0d idle cycles want 5", idle_cnt); else n_pass++;
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_read_latency();
        int ack_tick;
        logic [NREQ-1:0] ack_val;
        logic [DW-1:0] rd;
        ack_tick = 0; ack_val = '0; rd = '0;
        req[2] = 1'b1; req_we[2] = 1'b0; req_addr[2*AW +: AW] = 6'd7;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin
                n_checks++; if (gnt !== 3'b100) $display("FAIL rdlat_gnt: got %b want 100", gnt); else n_pass++;
            end
            if (ack != '0 && ack_tick == 0) begin
                ack_tick = i; ack_val = ack; rd = rdata; req[2] = 1'b0;
            end
        end
        n_checks++; if (ack_tick != 2 + RD_LAT) $display("FAIL rdlat_cycles: got %0d want %0d", ack_tick, 2 + RD_LAT); else n_pass++;
        n_checks++; if (ack_val !== 3'b100) $display("FAIL rdlat_ack: got %b want 100", ack_val); else n_pass++;
        n_checks++; if (rd !== 16'h002D) $display("FAIL rdlat_rdata: got %h want 002d", rd); else n_pass++;
        n_checks++; if (rdata !== 16'h002D) $display("FAIL rdlat_hold: got %h want 002d", rdata); else n_pass++;
    endtask

    task automatic test_withdrawal();
        logic saw_gnt1, saw_ack1, saw_we, saw_ack0;
        saw_gnt1 = 0; saw_ack1 = 0; saw_we = 0; saw_ack0 = 0;
        req[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: AW] = 6'd20;
        for (int c = 0; c < 14; c++) begin
            if (c == 2) begin
                req[1] = 1'b1; req_we[1] = 1'b1; req_addr[AW +: AW] = 6'd30; req_wdata[DW +: DW] = 16'hBEEF;
            end
            if (c == 3) req[1] = 1'b0;
            tick();
            if (gnt[1]) saw_gnt1 = 1;
            if (ack[1]) saw_ack1 = 1;
            if (ram_we) saw_we = 1;
            if (ack[0]) begin saw_ack0 = 1; req[0] = 1'b0; end
        end
        n_checks++; if (saw_gnt1 !== 1'b0) $display("FAIL wd_gnt1: got %b want 0", saw_gnt1); else n_pass++;
        n_checks++; if (saw_ack1 !== 1'b0) $display("FAIL wd_ack1: got %b want 0", saw_ack1); else n_pass++;
        n_checks++; if (saw_we !== 1'b0) $display("FAIL wd_ram_we: got %b want 0", saw_we); else n_pass++;
        n_checks++; if (mem[30] !== init_val(30)) $display("FAIL wd_mem: got %h want %h", mem[30], init_val(30)); else n_pass++;
        n_checks++; if (saw_ack0 !== 1'b1) $display("FAIL wd_ack0: got %b want 1", saw_ack0); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        int grants[$];
        int first_tick;
        logic [NREQ-1:0] prev;
        first_tick = 0; prev = '0;
        req[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: AW] = 6'd7;
        tick(); tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy_before: got %b want 1", busy); else n_pass++;
        req[2] = 1'b1; req_we[2] = 1'b0; req_addr[2*AW +: AW] = 6'd12;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if ({gnt, ack, busy, ram_we} !== '0) $display("FAIL rst_async_ctrl: got %b want 0", {gnt, ack, busy, ram_we}); else n_pass++;
        n_checks++; if ({ram_addr, ram_wdata, rdata} !== '0) $display("FAIL rst_async_data: got %h want 0", {ram_addr, ram_wdata, rdata}); else n_pass++;
        @(negedge clock);
        resetn = 1'b1;
        for (int c = 1; c <= 40 && grants.size() < 2; c++) begin
            tick();
            if (gnt != '0 && prev == '0) begin
                grants.push_back($clog2(gnt));
                if (grants.size() == 1) first_tick = c;
            end
            if (ack != '0) req = req & ~ack;
            prev = gnt;
        end
        n_checks++; if (grants.size() != 2) $display("FAIL rst_grants: got %0d want 2", grants.size()); else n_pass++;
        if (grants.size() == 2) begin
            n_checks++; if (grants[0] != 0) $display("FAIL rst_first: got %0d want 0", grants[0]); else n_pass++;
            n_checks++; if (grants[1] != 2) $display("FAIL rst_second: got %0d want 2", grants[1]); else n_pass++;
        end
        n_checks++; if (first_tick != 1) $display("FAIL rst_first_tick: got %0d want 1", first_tick); else n_pass++;
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_fairness();
        int grants[$];
        int gticks[$];
        int ack0_tick;
        logic [NREQ-1:0] prev;
        ack0_tick = 0; prev = '0;
        do_reset();
        req = 3'b101; req_we = 3'b101;
        req_addr[0 +: AW] = 6'd40; req_addr[2*AW +: AW] = 6'd41;
        for (int c = 1; c <= 40 && grants.size() < 4; c++) begin
            req_wdata[0 +: DW] = DW'($urandom);
            tick();
            if (gnt != '0 && prev == '0) begin
                grants.push_back($clog2(gnt));
                gticks.push_back(c);
            end
            if (ack[0] && ack0_tick == 0) ack0_tick = c;
            prev = gnt;
        end
        n_checks++; if (grants.size() != 4) $display("FAIL fair_count: got %0d want 4", grants.size()); else n_pass++;
        for (int i = 0; i < grants.size(); i++) begin
            n_checks++; if (grants[i] != ((i % 2 == 0) ? 0 : 2)) $display("FAIL fair_order[%0d]: got %0d want %0d", i, grants[i], (i % 2 == 0) ? 0 : 2); else n_pass++;
        end
        if (gticks.size() >= 2) begin
            n_checks++; if (gticks[1] != ack0_tick + 2) $display("FAIL fair_gap: got tick %0d want %0d", gticks[1], ack0_tick + 2); else n_pass++;
        end
        clear_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        logic [DW-1:0]   ref_mem [64];
        int              m_free, m_start, m_lat, m_g, m_last;
        logic            m_we, active, exp_we;
        logic [AW-1:0]   m_addr;
        logic [DW-1:0]   m_wdata, m_rd, m_rdata;
        logic [NREQ-1:0] exp_gnt, exp_ack;
        do_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        m_free = 0; m_start = -100; m_lat = 0; m_g = 0; m_last = NREQ - 1;
        m_we = 0; m_addr = '0; m_wdata = '0; m_rd = '0; m_rdata = '0;
        for (int e = 0; e < 1000; e++) begin
            tick();
            // Arbiter is free again one IDLE cycle after the previous ack.
            if (e >= m_free && req != '0) begin
                m_g = (m_last + 1) % NREQ;
                while (req[m_g] !== 1'b1) m_g = (m_g + 1) % NREQ;
                m_last  = m_g;
                m_start = e;
                m_we    = req_we[m_g];
                m_addr  = req_addr[m_g*AW +: AW];
                m_wdata = req_wdata[m_g*DW +: DW];
                m_lat   = m_we ? 2 : 2 + RD_LAT;
                m_free  = e + m_lat + 1;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_rd = ref_mem[m_addr];
            end
            active  = (e >= m_start) && (e < m_start + m_lat);
            exp_gnt = active ? (NREQ'(1) << m_g) : '0;
            exp_ack = (e == m_start + m_lat - 1) ? (NREQ'(1) << m_g) : '0;
            exp_we  = (e == m_start) && m_we;
            if (exp_ack != '0 && !m_we) m_rdata = m_rd;
            n_checks++; if (gnt !== exp_gnt) $display("FAIL rnd_gnt @%0d: got %b want %b", e, gnt, exp_gnt); else n_pass++;
            n_checks++; if (ack !== exp_ack) $display("FAIL rnd_ack @%0d: got %b want %b", e, ack, exp_ack); else n_pass++;
            n_checks++; if (busy !== active) $display("FAIL rnd_busy @%0d: got %b want %b", e, busy, active); else n_pass++;
            n_checks++; if (ram_we !== exp_we) $display("FAIL rnd_ram_we @%0d: got %b want %b", e, ram_we, exp_we); else n_pass++;
            n_checks++; if (ram_addr !== m_addr) $display("FAIL rnd_ram_addr @%0d: got %h want %h", e, ram_addr, m_addr); else n_pass++;
            n_checks++; if (ram_wdata !== m_wdata) $display("FAIL rnd_ram_wdata @%0d: got %h want %h", e, ram_wdata, m_wdata); else n_pass++;
            n_checks++; if (rdata !== m_rdata) $display("FAIL rnd_rdata @%0d: got %h want %h", e, rdata, m_rdata); else n_pass++;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_ack[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req[i] = 1'b1; req_we[i] = 1'($urandom_range(1));
                        req_addr[i*AW +: AW] = AW'($urandom_range(63)); req_wdata[i*DW +: DW] = DW'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (active && m_g == i) begin
                    if ($urandom_range(1) == 0) begin
                        req_we[i] = 1'($urandom_range(1));
                        req_addr[i*AW +: AW] = AW'($urandom_range(63)); req_wdata[i*DW +: DW] = DW'($urandom);
                    end
                    if ($urandom_range(7) == 0) req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(11) == 0) req[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    req[i] = 1'b1; req_we[i] = 1'($urandom_range(1));
                    req_addr[i*AW +: AW] = AW'($urandom_range(63)); req_wdata[i*DW +: DW] = DW'($urandom);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write();
        test_contention();
        test_read_latency();
        test_withdrawal();
        test_reset_mid_wait();
        test_fairness();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
